// File: rtl/verificacion_pin.sv
// PIN verification stage for the automatic cashier: captures BCD keypad digits,
// compares them with the card PIN and blocks the card after too many failed attempts.
module verificacion_pin #(
  parameter int unsigned N_DIGITOS    = 4,
  parameter int unsigned MAX_INTENTOS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tarjeta_recibida,
  input  logic [4*N_DIGITOS-1:0] pin_correcto,
  input  logic [3:0]             digito,
  input  logic                   digito_stb,
  output logic                   pin_ok,
  output logic                   pin_error,
  output logic                   advertencia,
  output logic                   bloqueo,
  output logic [1:0]             intentos
);

  localparam int unsigned    PinW      = 4 * N_DIGITOS;
  localparam int unsigned    CntW      = $clog2(N_DIGITOS + 1);
  localparam logic [CntW-1:0] UltimoCnt = CntW'(N_DIGITOS - 1);
  localparam logic [1:0]     MaxInt    = 2'(MAX_INTENTOS);
  localparam logic [1:0]     AvisoInt  = 2'(MAX_INTENTOS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCaptura,
    StCompara,
    StPinOk,
    StBloqueo
  } state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_count, w_count_d;
  logic [PinW-1:0] r_captura, w_captura_d;
  logic [1:0]      r_intentos, w_intentos_d;
  logic            r_pin_ok, w_pin_ok_d;
  logic            r_pin_error, w_pin_error_d;
  logic            r_advertencia, w_advertencia_d;
  logic            r_bloqueo, w_bloqueo_d;

  logic            w_retiro;
  logic            w_digito_valido;
  logic [1:0]      w_intentos_inc;

  // Card removal overrides any digit or compare result in the active states.
  assign w_retiro = !tarjeta_recibida &&
                    (r_state == StCaptura || r_state == StCompara || r_state == StPinOk);
  assign w_digito_valido = digito_stb && (digito <= 4'd9);
  assign w_intentos_inc  = (r_intentos == MaxInt) ? r_intentos : r_intentos + 2'd1;

  always_comb begin
    w_state_d       = r_state;
    w_count_d       = r_count;
    w_captura_d     = r_captura;
    w_intentos_d    = r_intentos;
    w_pin_ok_d      = r_pin_ok;
    w_pin_error_d   = 1'b0;
    w_advertencia_d = r_advertencia;
    w_bloqueo_d     = r_bloqueo;

    if (w_retiro) begin
      w_state_d       = StIdle;
      w_count_d       = '0;
      w_captura_d     = '0;
      w_intentos_d    = 2'd0;
      w_pin_ok_d      = 1'b0;
      w_advertencia_d = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (tarjeta_recibida) begin
            w_state_d       = StCaptura;
            w_count_d       = '0;
            w_captura_d     = '0;
            w_intentos_d    = 2'd0;
            w_advertencia_d = 1'b0;
          end
        end
        StCaptura: begin
          if (w_digito_valido) begin
            w_captura_d = (r_captura << 4) | PinW'(digito);
            w_count_d   = r_count + 1'b1;
            if (r_count == UltimoCnt) w_state_d = StCompara;
          end
        end
        StCompara: begin
          if (r_captura == pin_correcto) begin
            w_state_d  = StPinOk;
            w_pin_ok_d = 1'b1;
          end else begin
            w_intentos_d  = w_intentos_inc;
            w_pin_error_d = 1'b1;
            w_count_d     = '0;
            w_captura_d   = '0;
            if (w_intentos_inc == MaxInt) begin
              w_state_d       = StBloqueo;
              w_bloqueo_d     = 1'b1;
              w_advertencia_d = 1'b0;
            end else begin
              w_state_d       = StCaptura;
              w_advertencia_d = (w_intentos_inc == AvisoInt);
            end
          end
        end
        StPinOk: begin
          w_advertencia_d = 1'b0;
        end
        StBloqueo: begin
          w_bloqueo_d = 1'b1;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_captura     <= '0;
      r_intentos    <= 2'd0;
      r_pin_ok      <= 1'b0;
      r_pin_error   <= 1'b0;
      r_advertencia <= 1'b0;
      r_bloqueo     <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_count       <= w_count_d;
      r_captura     <= w_captura_d;
      r_intentos    <= w_intentos_d;
      r_pin_ok      <= w_pin_ok_d;
      r_pin_error   <= w_pin_error_d;
      r_advertencia <= w_advertencia_d;
      r_bloqueo     <= w_bloqueo_d;
    end
  end

  assign pin_ok      = r_pin_ok;
  assign pin_error   = r_pin_error;
  assign advertencia = r_advertencia;
  assign bloqueo     = r_bloqueo;
  assign intentos    = r_intentos;

endmodule

// File: tb/tb_verificacion_pin.sv
// Self-checking bench for verificacion_pin: expected attempt outcomes are queued when the
// last digit is driven and compared when the DUT reports pin_ok or pin_error.
module tb_verificacion_pin;

  logic        clk;
  logic        reset;
  logic        tarjeta_recibida;
  logic [15:0] pin_correcto;
  logic [3:0]  digito;
  logic        digito_stb;
  logic        pin_ok;
  logic        pin_error;
  logic        advertencia;
  logic        bloqueo;
  logic [1:0]  intentos;

  typedef struct {
    bit       ok;
    bit       err;
    bit       adv;
    bit       adv_chk;
    bit       bloq;
    int       nint;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;
  int   err_pulses;

  verificacion_pin #(
    .N_DIGITOS    (4),
    .MAX_INTENTOS (3)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .tarjeta_recibida (tarjeta_recibida),
    .pin_correcto     (pin_correcto),
    .digito           (digito),
    .digito_stb       (digito_stb),
    .pin_ok           (pin_ok),
    .pin_error        (pin_error),
    .advertencia      (advertencia),
    .bloqueo          (bloqueo),
    .intentos         (intentos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (reset && pin_error) err_pulses++;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] d);
    digito     = d;
    digito_stb = 1'b1;
    tick();
    digito_stb = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] p);
    strobe(p[15:12]);
    strobe(p[11:8]);
    strobe(p[7:4]);
    strobe(p[3:0]);
  endtask

  task automatic push_exp(input bit ok, input bit err, input bit adv, input bit adv_chk,
                          input bit bloq, input int nint);
    exp_t e;
    e.ok = ok; e.err = err; e.adv = adv; e.adv_chk = adv_chk; e.bloq = bloq; e.nint = nint;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the attempt outcome and compares it with the queued expectation.
  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (pin_ok || pin_error) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_latency"}, lat, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_pin_ok"}, int'(pin_ok), int'(e.ok));
      check_eq({tag, "_pin_error"}, int'(pin_error), int'(e.err));
      check_eq({tag, "_bloqueo"}, int'(bloqueo), int'(e.bloq));
      check_eq({tag, "_intentos"}, int'(intentos), e.nint);
      if (e.adv_chk) check_eq({tag, "_advertencia"}, int'(advertencia), int'(e.adv));
    end
  endtask

  task automatic attempt(input string tag, input logic [15:0] p, input bit ok, input bit adv,
                         input bit adv_chk, input bit bloq, input int nint);
    enter4(p);
    push_exp(ok, !ok, adv, adv_chk, bloq, nint);
    wait_result(tag);
  endtask

  initial begin
    int pulses0;
    n_checks = 0; n_errors = 0; err_pulses = 0;
    pin_correcto = 16'h1234;
    reset = 1'b0; tarjeta_recibida = 1'b1; digito = 4'd1; digito_stb = 1'b1;

    // 1: reset dominates card and strobes
    tick(); tick();
    check_eq("rst_pin_ok", int'(pin_ok), 0);
    check_eq("rst_pin_error", int'(pin_error), 0);
    check_eq("rst_advertencia", int'(advertencia), 0);
    check_eq("rst_bloqueo", int'(bloqueo), 0);
    check_eq("rst_intentos", int'(intentos), 0);
    digito_stb = 1'b0;
    reset = 1'b1;
    tick();

    // 2: correct PIN first time
    pulses0 = err_pulses;
    attempt("ok_first", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    tick();
    check_eq("ok_first_held", int'(pin_ok), 1);
    check_eq("ok_first_no_err", err_pulses - pulses0, 0);
    tarjeta_recibida = 1'b0; tick();
    check_eq("remove_pin_ok", int'(pin_ok), 0);

    // 3: one failure then success
    tarjeta_recibida = 1'b1; tick();
    attempt("fail1", 16'h1235, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    tick();
    check_eq("fail1_pulse_end", int'(pin_error), 0);
    attempt("ok_after_fail", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    tarjeta_recibida = 1'b0; tick();
    check_eq("remove_intentos", int'(intentos), 0);

    // 4: three failures block the card
    tarjeta_recibida = 1'b1; tick();
    attempt("blk1", 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    tick();
    attempt("blk2", 16'h9999, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    tick();
    attempt("blk3", 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    tarjeta_recibida = 1'b0;
    tick();
    strobe(4'd1); tick();
    check_eq("blk_held", int'(bloqueo), 1);
    check_eq("blk_intentos_sat", int'(intentos), 3);
    check_eq("blk_no_ok", int'(pin_ok), 0);
    reset = 1'b0; tick();
    check_eq("blk_reset", int'(bloqueo), 0);
    check_eq("blk_reset_intentos", int'(intentos), 0);
    reset = 1'b1;

    // 5: non-BCD digits ignored; removal mid-capture restarts clean
    tarjeta_recibida = 1'b1; tick();
    strobe(4'd1); strobe(4'hA); strobe(4'd2); strobe(4'hF); strobe(4'd3);
    strobe(4'd4);
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    wait_result("skip_hex");
    tarjeta_recibida = 1'b0; tick();
    tarjeta_recibida = 1'b1; tick();
    strobe(4'd1); strobe(4'd2);
    tarjeta_recibida = 1'b0; tick();
    tarjeta_recibida = 1'b1; tick();
    attempt("restart_clean", 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 0);

    // 6: removal on the 4th strobe wins; reset in PIN_OK
    tarjeta_recibida = 1'b0; tick();
    tarjeta_recibida = 1'b1; tick();
    pulses0 = err_pulses;
    strobe(4'd1); strobe(4'd2); strobe(4'd3);
    tarjeta_recibida = 1'b0;
    strobe(4'd4);
    tick(); tick();
    check_eq("rm4_pin_ok", int'(pin_ok), 0);
    check_eq("rm4_no_err", err_pulses - pulses0, 0);
    // pin_correcto changes outside COMPARA have no effect
    tarjeta_recibida = 1'b1; tick();
    pin_correcto = 16'h5678;
    strobe(4'd5); strobe(4'd6); strobe(4'd7);
    pin_correcto = 16'h1234;
    strobe(4'd8);
    pin_correcto = 16'h5678;
    push_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    wait_result("pin_sampled");
    pin_correcto = 16'h0000;
    tick();
    check_eq("pin_change_after", int'(pin_ok), 1);
    reset = 1'b0; tick();
    check_eq("rst_in_pin_ok", int'(pin_ok), 0);
    reset = 1'b1; tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/verificacion_pin.md
Name: verificacion_pin

Overview:
PIN-verification stage that sits directly upstream of the transaction block in the automatic cashier. After a card is inserted it captures BCD PIN digits from the keypad one strobe at a time and compares them with the PIN read from the card. It allows at most MAX_INTENTOS attempts. A successful match raises pin_ok, which the top level uses to gate the transaction block's tarjeta_recibida. Exhausting all attempts latches a card block.

Parameters:
N_DIGITOS, 4, number of BCD digits per PIN; PIN width = 4*N_DIGITOS.
MAX_INTENTOS, 3, failed attempts allowed before blocking; legal range 1..3.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset.
tarjeta_recibida  input  1  level; high while a card is inserted.
pin_correcto  input  4*N_DIGITOS  stored PIN from the card, BCD; most significant nibble is the first digit.
digito  input  4  keypad digit (BCD).
digito_stb  input  1  one-cycle strobe; digito is valid in that cycle.
pin_ok  output  1  level; PIN verified for the current card.
pin_error  output  1  one-cycle pulse per failed attempt.
advertencia  output  1  level; exactly one attempt remains.
bloqueo  output  1  level; card blocked.
intentos  output  2  number of failed attempts so far.

Behaviour:
- Interface fixed: one clock (clk). Reset is synchronous and active-low: reset==0 at a rising edge of clk resets the block.
- Reset values: state IDLE; pin_ok, pin_error, advertencia, bloqueo = 0; intentos = 0; internal digit count = 0; capture register = 0.
- Reset has priority over all other inputs in every state, including mid-capture and BLOQUEO.
- States:
  - IDLE
    - tarjeta_recibida==1 -> CAPTURA. Clear digit count, capture register, intentos, advertencia.
    - digito_stb is ignored.
  - CAPTURA
    - digito_stb==1 and digito<=9: shift digito into the LSB nibble of the capture register; count+1.
    - digito_stb==1 and digito>9: ignored; no shift, no count change.
    - On the edge that accepts the N_DIGITOS-th digit: -> COMPARA.
  - COMPARA: lasts exactly one cycle.
    - Capture == pin_correcto -> PIN_OK; pin_ok goes to 1 on this edge.
    - Mismatch: intentos+1; pin_error=1 for exactly one cycle; capture and count cleared.
      - If the new intentos == MAX_INTENTOS -> BLOQUEO with bloqueo=1.
      - Otherwise -> CAPTURA; advertencia=1 if the new intentos == MAX_INTENTOS-1.
    - digito_stb is ignored.
  - PIN_OK
    - pin_ok held at 1; digito_stb ignored.
    - advertencia cleared; intentos holds its value.
  - BLOQUEO
    - bloqueo held at 1; ignores tarjeta_recibida and digito_stb. The card is retained.
    - Exits only through reset.
- Card removal: tarjeta_recibida==0 in CAPTURA, COMPARA or PIN_OK -> IDLE on that edge. Clears pin_ok, advertencia, intentos, count and capture. pin_error is not raised. Removal takes priority over a simultaneous digito_stb or compare result.
- Latency: last digit accepted at edge k -> pin_ok or pin_error asserted at edge k+1.
- pin_correcto is sampled only in COMPARA. Changes to it at other times have no effect.
- intentos saturates at MAX_INTENTOS and never wraps.

Test Plan:
1. reset=0 for 2 edges with tarjeta_recibida=1 and digito_stb pulses -> all outputs 0, state IDLE; after release, the card starts capture.
2. pin_correcto=16'h1234; insert card, strobe 1,2,3,4 on consecutive cycles -> pin_ok=1 one edge after digit 4, pin_error never asserted, intentos=0.
3. Enter 1,2,3,5 -> pin_error one-cycle pulse, intentos=1, advertencia=0. Then enter 1,2,3,4 -> pin_ok=1, intentos stays 1.
4. Three wrong PINs (9,9,9,9 each) -> advertencia=1 after the 2nd failure; bloqueo=1 and intentos=3 after the 3rd. Drop tarjeta_recibida -> bloqueo stays 1. Apply reset -> bloqueo=0.
5. Strobe 1, 4'hA, 2, 3, 4 -> 4'hA ignored, pin_ok=1. Drop tarjeta_recibida after 2 digits, reinsert and enter 1234 -> pin_ok=1, showing capture restarted clean.
6. Card removed on the same cycle as the 4th digit strobe -> IDLE, pin_ok=0, pin_error=0. Reset asserted in PIN_OK -> pin_ok=0 on that edge.
